// File: rtl/mem_responder_if.sv
// mem_responder_if: access/response bundle for mem_responder.
// The master side issues accesses (ce/wre/ad/din, plus oce for the output
// register). The slave side returns read data, the ready flag and the sticky
// early-access error flag.
`timescale 1ns/1ps
interface mem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          ce;
  logic          oce;
  logic          wre;
  logic [AW-1:0] ad;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          ready;
  logic          err;

  modport master (
    output ce, oce, wre, ad, din,
    input  dout, ready, err
  );

  modport slave (
    input  ce, oce, wre, ad, din,
    output dout, ready, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port 2^AW x DW memory that zero-fills itself after
// reset (CLEAR sweep, one word per cycle) and then serves reads and writes
// (SERVE). Writes use no-change mode, so the read register is left untouched.
// Any access attempted during the sweep is dropped and sets the sticky err.
// Optional feature macro: MEM_PIPELINE_EN adds an output register (oreg)
// gated by oce; without it dout is driven straight from the read register
// and oce is ignored.
`timescale 1ns/1ps
module mem_responder #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_ready;
  logic          r_err;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [2**AW];

  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_rd_en;
  logic          w_err_set;

  // Next state and memory port control: the sweep owns the write port in
  // CLEAR, the external access owns it in SERVE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.ad;
    w_mem_wdata = bus.din;
    w_rd_en     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_cnt;
        w_mem_wdata = {DW{1'b0}};
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_err_set   = bus.ce;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_SERVE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_SERVE: begin
        // SERVE is terminal; only rst leads back to CLEAR.
        w_state_nxt = ST_SERVE;
        w_mem_we    = bus.ce & bus.wre;
        w_rd_en     = bus.ce & ~bus.wre;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = {AW{1'b0}};
      end
    endcase
  end

  // State, sweep counter, registered ready/err flags and the read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= {AW{1'b0}};
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= {DW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_SERVE);
      r_err   <= r_err | w_err_set;
      if (w_rd_en) begin
        r_rdata <= r_mem[bus.ad];
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Memory array write port; contents are only ever zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign bus.ready = r_ready;
  assign bus.err   = r_err;

`ifdef MEM_PIPELINE_EN
  logic [DW-1:0] r_oreg;

  // Output register: adds one cycle of read latency, advanced only by oce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oreg <= {DW{1'b0}};
    end else if (bus.oce) begin
      r_oreg <= r_rdata;
    end else begin
      r_oreg <= r_oreg;
    end
  end

  assign bus.dout = r_oreg;
`else
  logic w_unused_oce;
  assign w_unused_oce = bus.oce;
  assign bus.dout     = r_rdata;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a read scoreboard.
// Stimulus pushes the expected word for each tracked read; an independent
// monitor pops and compares once the read latency has elapsed.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int AW = 8;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exp_rd = 1'b0;
  logic        mon_d1 = 1'b0;
  logic        mon_d2 = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [31:0] sb [$];

  mem_responder_if #(.AW(AW), .DW(DW)) bus ();

  mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.ce  = 1'b0;
    bus.wre = 1'b0;
    exp_rd  = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.ce  = 1'b1;
    bus.wre = 1'b1;
    bus.ad  = a;
    bus.din = d;
    exp_rd  = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    bus.ce  = 1'b1;
    bus.wre = 1'b0;
    bus.ad  = a;
    exp_rd  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic early_pulse();
    bus.ce  = 1'b1;
    bus.wre = 1'b1;
    bus.ad  = 8'h05;
    bus.din = 32'h0000_1234;
    exp_rd  = 1'b0;
  endtask

  // Monitor: delays each tracked read by the output latency, then compares.
  initial begin
    forever begin
      @(posedge clk);
      mon_d2 = mon_d1 & bus.oce;
      mon_d1 = exp_rd;
      @(negedge clk);
`ifdef MEM_PIPELINE_EN
      if (mon_d2) begin
`else
      if (mon_d1) begin
`endif
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=empty required=entry");
        end else begin
          chk("read_data", bus.dout, sb.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.oce = 1'b1;
    bus.ad  = 8'h00;
    bus.din = 32'h0;
    repeat (3) cyc();
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_err",   {31'b0, bus.err},   32'h0);
    chk("rst_dout",  bus.dout,           32'h0);

    // Clear sweep with an early write attempt at sweep cycle 50.
    rst = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      cyc();
      n++;
      if (n == 50) early_pulse();
      else if (n == 51) begin
        chk("early_err", {31'b0, bus.err}, 32'h1);
        idle();
      end
    end
    chk("sweep_len",  n, 32'd256);
    chk("err_sticky", {31'b0, bus.err}, 32'h1);

    // Swept memory reads zero, including the early-write target.
    rd(8'h00, 32'h0);
    rd(8'h7F, 32'h0);
    rd(8'hFF, 32'h0);
    rd(8'h05, 32'h0);
    idle();
    cyc();

    // ce=0 with wre=1 must not write.
    bus.ce  = 1'b0;
    bus.wre = 1'b1;
    bus.ad  = 8'h30;
    bus.din = 32'hCAFE_F00D;
    cyc();
    idle();
    rd(8'h30, 32'h0);
    idle();
    cyc();

    // Write then read next cycle; dout unchanged over the write.
    wr(8'h10, 32'hDEAD_BEEF);
    chk("write_no_change", bus.dout, 32'h0);
    rd(8'h10, 32'hDEAD_BEEF);
    idle();
    repeat (2) cyc();

    // Hold for 10 idle cycles.
    wr(8'h20, 32'hA5A5_A5A5);
    wr(8'h21, 32'h5A5A_5A5A);
    rd(8'h20, 32'hA5A5_A5A5);
    idle();
    repeat (10) cyc();
    chk("hold", bus.dout, 32'hA5A5_A5A5);
`ifdef MEM_PIPELINE_EN
    bus.oce = 1'b0;
    bus.ce  = 1'b1;
    bus.wre = 1'b0;
    bus.ad  = 8'h21;
    cyc();
    idle();
    cyc();
    chk("oce_hold", bus.dout, 32'hA5A5_A5A5);
    bus.oce = 1'b1;
    cyc();
    chk("oce_load", bus.dout, 32'h5A5A_5A5A);
`endif

    // Address wrap, back-to-back reads.
    wr(8'hFF, 32'hFFFF_FFFF);
    wr(8'h00, 32'h0000_0001);
    rd(8'hFF, 32'hFFFF_FFFF);
    rd(8'h00, 32'h0000_0001);
    rd(8'hFE, 32'h0);
    rd(8'h00, 32'h0000_0001);
    idle();
    repeat (2) cyc();

    // Asynchronous reset while serving clears flags and dout at once.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'b0, bus.ready}, 32'h0);
    chk("arst_err",   {31'b0, bus.err},   32'h1 ^ 32'h1);
    chk("arst_dout",  bus.dout,           32'h0);
    repeat (2) cyc();
    rst = 1'b0;

    // Sweep to cycle 100 with err set, then reset mid-sweep.
    n = 0;
    while (n < 100) begin
      cyc();
      n++;
      if (n == 10) early_pulse();
      else if (n == 11) idle();
    end
    chk("mid_err_set", {31'b0, bus.err},   32'h1);
    chk("mid_ready",   {31'b0, bus.ready}, 32'h0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_err",   {31'b0, bus.err},   32'h0);
    chk("mid_rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("mid_rst_dout",  bus.dout,           32'h0);
    cyc();
    rst = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    chk("resweep_len", n, 32'd256);
    chk("resweep_err", {31'b0, bus.err}, 32'h0);

    // Second sweep zeroed previously written words.
    rd(8'h10, 32'h0);
    rd(8'hFF, 32'h0);
    rd(8'h00, 32'h0);
    idle();
    repeat (3) cyc();
    chk("sb_empty", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
